// File: rtl/lfm_responder_if.sv
// rtl/lfm_responder_if.sv - MMU page-walk request port and memory read port bundle
interface lfm_responder_if;
    logic [3:0]  hazard_signal;
    logic        LFM_enable;
    logic [31:0] LFM;
    logic        LFM_resolved;
    logic [31:0] LFM_word;
    logic        lfm_err;
    logic        core_mem_busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output hazard_signal, LFM_enable, LFM, core_mem_busy, mem_gnt, mem_rvalid, mem_rdata,
        input  LFM_resolved, LFM_word, lfm_err, mem_req, mem_addr
    );

    modport slave (
        input  hazard_signal, LFM_enable, LFM, core_mem_busy, mem_gnt, mem_rvalid, mem_rdata,
        output LFM_resolved, LFM_word, lfm_err, mem_req, mem_addr
    );
endinterface

// File: rtl/lfm_responder.sv
// rtl/lfm_responder.sv - services MMU page-walk PTE reads over a shared memory read port
`ifndef FLUSH_ALL
`define FLUSH_ALL 4'hF
`endif

module lfm_responder #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    lfm_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, RESP, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] word_q;
    logic [9:0]  cnt;
    logic        err_q;
    logic        drain_q;
    logic        resolved_q;
    logic        flush;
    logic        cnt_last;

    assign flush    = (bus.hazard_signal == `FLUSH_ALL);
    assign cnt_last = ((cnt + 10'd1) == 10'(TIMEOUT));

    // A flush also masks the issue so an aborted request never leaves a read in flight.
    assign bus.mem_req      = (state == ISSUE) && !bus.core_mem_busy && !flush;
    assign bus.mem_addr     = bus.mem_req ? addr_q : 32'd0;
    assign bus.LFM_resolved = resolved_q && !flush;
    assign bus.lfm_err      = resolved_q && err_q && !flush;
    assign bus.LFM_word     = word_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= 32'd0;
            word_q     <= 32'd0;
            cnt        <= 10'd0;
            err_q      <= 1'b0;
            drain_q    <= 1'b0;
            resolved_q <= 1'b0;
        end else begin
            resolved_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.LFM_enable && !flush) begin
                        addr_q  <= bus.LFM;
                        word_q  <= 32'd0;
                        err_q   <= 1'b0;
                        drain_q <= 1'b0;
                        if (bus.LFM[1:0] != 2'b00) begin
                            err_q      <= 1'b1;
                            resolved_q <= 1'b1;
                            state      <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (bus.mem_req && bus.mem_gnt) begin
                        cnt   <= 10'd0;
                        state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    // A beat arriving with the flush is consumed here, so nothing is left to drain.
                    if (flush) begin
                        cnt   <= 10'd0;
                        state <= bus.mem_rvalid ? IDLE : DRAIN;
                    end else if (bus.mem_rvalid) begin
                        word_q     <= bus.mem_rdata;
                        resolved_q <= 1'b1;
                        state      <= RESP;
                    end else if (cnt_last) begin
                        word_q     <= 32'd0;
                        err_q      <= 1'b1;
                        drain_q    <= 1'b1;
                        resolved_q <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                RESP: begin
                    if (flush) begin
                        cnt     <= 10'd0;
                        drain_q <= 1'b0;
                        state   <= drain_q ? DRAIN : IDLE;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush || !bus.LFM_enable) begin
                        cnt     <= 10'd0;
                        drain_q <= 1'b0;
                        state   <= drain_q ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (bus.mem_rvalid || cnt_last) begin
                        cnt   <= 10'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
